// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data channel between the MEM-stage access controller and memory.
// Request fields are held stable while data_req=1; data_addr_ok accepts the request,
// and data_data_ok marks the cycle where data_rdata is valid.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: decodes the access, raises address errors,
// and runs one SRAM-like transaction per aligned access through IDLE/ADDR/DATA/DONE.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        validM,
  input  logic [5:0]  op,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        pipe_stall,
  mem_access_ctrl_if.master mem,
  output logic [31:0] readdataM,
  output logic        stall_mem,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  output logic [1:0]  state_dbg
);
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic        is_load, is_store, misalign, access, start;
  logic [1:0]  size_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        capture, set_discard, latch_rd;

  logic        discard_q, wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    size_d   = 2'd0;
    wdata_d  = writedataM;
    wstrb_d  = 4'b0000;
    case (op)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        size_d   = 2'd1;
        misalign = aluoutM[0];
      end
      OP_LW: begin
        is_load  = 1'b1;
        size_d   = 2'd2;
        misalign = |aluoutM[1:0];
      end
      OP_SB: begin
        is_store = 1'b1;
        wdata_d  = {4{writedataM[7:0]}};
        wstrb_d  = 4'b0001 << aluoutM[1:0];
      end
      OP_SH: begin
        is_store = 1'b1;
        size_d   = 2'd1;
        misalign = aluoutM[0];
        wdata_d  = {2{writedataM[15:0]}};
        wstrb_d  = aluoutM[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        is_store = 1'b1;
        size_d   = 2'd2;
        misalign = |aluoutM[1:0];
        wstrb_d  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign access   = validM & (is_load | is_store);
  assign start    = access & ~misalign & ~flushM;
  assign adel     = access & is_load & misalign;
  assign ades     = access & is_store & misalign;
  assign badvaddr = (adel | ades) ? aluoutM : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    set_discard = 1'b0;
    latch_rd    = 1'b0;
    stall_mem   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          stall_mem = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        stall_mem = 1'b1;
        if (mem.data_addr_ok) begin
          // A request already accepted must still have its response drained.
          set_discard = flushM;
          state_nxt   = DATA;
        end else if (flushM) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        stall_mem = 1'b1;
        if (mem.data_data_ok) begin
          latch_rd  = ~wr_q & ~discard_q & ~flushM;
          state_nxt = (discard_q | flushM) ? IDLE : DONE;
        end
      end
      DONE: begin
        if (!pipe_stall || flushM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'b0000;
      rdata_q   <= 32'h0;
    end else begin
      if (capture) begin
        wr_q    <= is_store;
        size_q  <= size_d;
        addr_q  <= aluoutM;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
      end
      if (set_discard)             discard_q <= 1'b1;
      else if (state_nxt == IDLE)  discard_q <= 1'b0;
      if (latch_rd)                rdata_q   <= mem.data_rdata;
    end
  end

  assign mem.data_req   = (state == ADDR);
  assign mem.data_wr    = wr_q;
  assign mem.data_size  = size_q;
  assign mem.data_addr  = addr_q;
  assign mem.data_wdata = wdata_q;
  assign mem.data_wstrb = wstrb_q;
  assign readdataM      = rdata_q;
  assign state_dbg      = state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses, with a
// memory responder and an arithmetic reference model of decode and readdataM.
module tb_mem_access_ctrl;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        validM, flushM, pipe_stall;
  logic [5:0]  op;
  logic [31:0] aluoutM, writedataM;
  logic [31:0] readdataM, badvaddr;
  logic        stall_mem, adel, ades;
  logic [1:0]  state_dbg;

  mem_access_ctrl_if mem_bus();

  mem_access_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .validM     (validM),
    .op         (op),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .pipe_stall (pipe_stall),
    .mem        (mem_bus.master),
    .readdataM  (readdataM),
    .stall_mem  (stall_mem),
    .adel       (adel),
    .ades       (ades),
    .badvaddr   (badvaddr),
    .state_dbg  (state_dbg)
  );

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // reference model: access width in bytes drives everything else
  task automatic model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output bit ld, output bit st, output bit mis, output logic [1:0] sz,
                       output logic [31:0] wdat, output logic [3:0] strb);
    int bytes;
    ld    = (o == LB) || (o == LBU) || (o == LH) || (o == LHU) || (o == LW);
    st    = (o == SB) || (o == SH) || (o == SW);
    bytes = (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
    sz    = (bytes == 4) ? 2'd2 : (bytes == 2) ? 2'd1 : 2'd0;
    mis   = (ld || st) && ((a % bytes) != 0);
    wdat  = (bytes == 1) ? (wd & 32'hFF) * 32'h01010101 :
            (bytes == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    strb  = st ? 4'(((1 << bytes) - 1) << (a % 4)) : 4'b0000;
  endtask

  task automatic idle_inputs();
    validM = 1'b0; op = 6'h0; aluoutM = 32'h0; writedataM = 32'h0;
    flushM = 1'b0; pipe_stall = 1'b0;
    mem_bus.data_addr_ok = 1'b0; mem_bus.data_data_ok = 1'b0; mem_bus.data_rdata = 32'h0;
  endtask

  task automatic present(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    validM = 1'b1; op = o; aluoutM = a; writedataM = wd;
    flushM = 1'b0; pipe_stall = 1'b0;
    mem_bus.data_addr_ok = 1'b0; mem_bus.data_data_ok = 1'b0;
    #1;
  endtask

  // one full access, with the memory responding after the given delays
  task automatic run_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                            input int a_dly, input int d_dly, input int ps_dly);
    bit ld, st, mis;
    logic [1:0]  sz;
    logic [31:0] wdat, rdat;
    logic [3:0]  strb;
    model(o, a, wd, ld, st, mis, sz, wdat, strb);
    present(o, a, wd);
    if (!(ld || st) || mis) begin
      check("adel", adel, 32'(ld && mis));
      check("ades", ades, 32'(st && mis));
      check("badvaddr", badvaddr, mis ? a : 32'h0);
      check("stall_noacc", stall_mem, 0);
      check("req_noacc", mem_bus.data_req, 0);
      @(posedge clk); #1;
      check("req_noacc_next", mem_bus.data_req, 0);
      validM = 1'b0;
      return;
    end
    check("stall_start", stall_mem, 1);
    check("exc_aligned", adel | ades, 0);
    check("req_idle", mem_bus.data_req, 0);
    for (int i = 0; i <= a_dly; i++) begin
      @(posedge clk); #1;
      mem_bus.data_addr_ok = (i == a_dly);
      mem_bus.data_data_ok = 1'($urandom_range(0, 1));
      mem_bus.data_rdata   = $urandom;
      #1;
      check("req_addr", mem_bus.data_req, 1);
      check("addr", mem_bus.data_addr, a);
      check("size", mem_bus.data_size, sz);
      check("wr", mem_bus.data_wr, 32'(st));
      check("wstrb", mem_bus.data_wstrb, strb);
      if (st) check("wdata", mem_bus.data_wdata, wdat);
      check("stall_addr", stall_mem, 1);
    end
    rdat = 32'h0;
    for (int i = 0; i <= d_dly; i++) begin
      @(posedge clk); #1;
      mem_bus.data_addr_ok = 1'b0;
      mem_bus.data_data_ok = (i == d_dly);
      rdat = $urandom;
      mem_bus.data_rdata = rdat;
      #1;
      check("req_data", mem_bus.data_req, 0);
      check("stall_data", stall_mem, 1);
    end
    if (ld) exp_q.push_back(rdat);
    for (int i = 0; i <= ps_dly; i++) begin
      @(posedge clk); #1;
      pipe_stall = (i < ps_dly);
      mem_bus.data_data_ok = 1'($urandom_range(0, 1));
      mem_bus.data_rdata   = $urandom;
      #1;
      if (i == 0 && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      check("stall_done", stall_mem, 0);
      check("req_done", mem_bus.data_req, 0);
      check("readdata", readdataM, exp_rd);
    end
    @(posedge clk); #1;
    validM = 1'b0; pipe_stall = 1'b0; mem_bus.data_data_ok = 1'b0;
    #1;
    check("idle_after", state_dbg, 0);
    check("readdata_hold", readdataM, exp_rd);
  endtask

  // mode 0: flush before acceptance; 1: flush with acceptance; 2: as 1, reset in DATA
  task automatic run_flush(input int mode);
    present(LW, 32'h0000_4000, 32'h0);
    check("fl_stall_start", stall_mem, 1);
    @(posedge clk); #1;
    check("fl_req", mem_bus.data_req, 1);
    @(posedge clk); #1;
    flushM = 1'b1;
    mem_bus.data_addr_ok = (mode != 0);
    #1;
    check("fl_req_flush", mem_bus.data_req, 1);
    @(posedge clk); #1;
    flushM = 1'b0; validM = 1'b0; mem_bus.data_addr_ok = 1'b0;
    #1;
    if (mode == 0) begin
      check("fl0_req", mem_bus.data_req, 0);
      check("fl0_state", state_dbg, 0);
      check("fl0_stall", stall_mem, 0);
      @(posedge clk); #2;
      check("fl0_req_next", mem_bus.data_req, 0);
      return;
    end
    check("fl_req_data", mem_bus.data_req, 0);
    check("fl_stall_data", stall_mem, 1);
    if (mode == 1) begin
      @(posedge clk); #1;
      mem_bus.data_data_ok = 1'b1;
      mem_bus.data_rdata   = $urandom;
      @(posedge clk); #1;
      mem_bus.data_data_ok = 1'b0;
      #1;
      check("fl1_state", state_dbg, 0);
      check("fl1_readdata", readdataM, exp_rd);
      check("fl1_stall", stall_mem, 0);
      check("fl1_req", mem_bus.data_req, 0);
    end else begin
      #2;
      resetn = 1'b0;
      #1;
      exp_rd = 32'h0;
      check("rst_req", mem_bus.data_req, 0);
      check("rst_wr", mem_bus.data_wr, 0);
      check("rst_size", mem_bus.data_size, 0);
      check("rst_addr", mem_bus.data_addr, 0);
      check("rst_wdata", mem_bus.data_wdata, 0);
      check("rst_wstrb", mem_bus.data_wstrb, 0);
      check("rst_readdata", readdataM, 0);
      check("rst_stall", stall_mem, 0);
      check("rst_state", state_dbg, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #2;
        check("rst_no_req", mem_bus.data_req, 0);
        check("rst_idle", state_dbg, 0);
      end
    end
  endtask

  logic [5:0] op_tab [11];

  initial begin
    op_tab = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 6'h00, 6'h08, 6'h0f};
    exp_rd = 32'h0;
    idle_inputs();
    resetn = 1'b0;
    #12;
    check("reset_req", mem_bus.data_req, 0);
    check("reset_readdata", readdataM, 0);
    check("reset_wstrb", mem_bus.data_wstrb, 0);
    check("reset_state", state_dbg, 0);
    check("reset_stall", stall_mem, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_access(LW, 32'h0000_1000, 32'h0, 0, 0, 0);
    check("lw_deadbeef_path", 32'(exp_q.size()), 0);
    run_access(SB, 32'h0000_2003, 32'h0000_00A5, 0, 0, 0);
    run_access(SH, 32'h0000_2002, 32'h0000_1234, 1, 0, 0);
    run_access(LH, 32'h0000_2001, 32'h0, 0, 0, 0);
    run_access(SW, 32'h0000_3002, 32'h0, 0, 0, 0);
    run_access(LW, 32'h0000_1004, 32'h0, 4, 2, 2);
    run_access(SW, 32'h0000_1008, 32'hCAFE_F00D, 0, 1, 1);

    run_flush(0);
    run_flush(1);
    run_flush(2);

    for (int n = 0; n < 60; n++) begin
      logic [5:0]  o;
      logic [31:0] a;
      o = op_tab[$urandom_range(0, 10)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (o == SB || o == LB || o == LBU) ? a[1:0] :
                                              (o == SH || o == LH || o == LHU) ? {a[1], 1'b0} : 2'b00;
      run_access(o, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide ports: clk in 1, single clock, all state on rising edge; resetn in 1, asynchronous active-low reset.
REQ-002 SHALL provide validM in 1: MEM stage holds a live instruction.
REQ-003 SHALL provide op in 6: MEM-stage opcode, OP_* values from opcodedefines.vh.
REQ-004 SHALL provide aluoutM in 32: byte address; writedataM in 32: rt store value.
REQ-005 SHALL provide flushM in 1: cancel the MEM instruction; pipe_stall in 1: another stage holds MEM.
REQ-006 SHALL provide data_req out 1, data_wr out 1, data_size out 2, data_addr out 32, data_wdata out 32, data_wstrb out 4: SRAM-like request channel.
REQ-007 SHALL provide data_addr_ok in 1, data_data_ok in 1, data_rdata in 32: SRAM-like response channel.
REQ-008 SHALL provide readdataM out 32: raw loaded word for the load-extract stage; stall_mem out 1: MEM not finished.
REQ-009 SHALL provide adel out 1, ades out 1, badvaddr out 32: load/store address-error exception.

Function
REQ-010 SHALL treat LB, LBU, LH, LHU, LW as loads and SB, SH, SW as stores; any other op is a non-access.
REQ-011 SHALL set misalignment when LW/SW has aluoutM[1:0]!=00 or LH/LHU/SH has aluoutM[0]=1.
REQ-012 SHALL drive adel/ades combinationally when validM=1, the op is a load/store, and misaligned; badvaddr=aluoutM then, else 0.
REQ-013 SHALL issue no request for a misaligned, flushed, invalid, or non-access instruction.
REQ-014 SHALL implement FSM IDLE, ADDR, DATA, DONE.
REQ-015 IDLE: on a valid aligned access with flushM=0, latch address, size, wr, wdata, and wstrb, then go to ADDR.
REQ-016 ADDR: data_req=1 with latched fields stable; data_addr_ok=1 goes to DATA; flushM=1 with data_addr_ok=0 goes to IDLE with data_req dropped.
REQ-017 ADDR: flushM=1 and data_addr_ok=1 in the same cycle SHALL go to DATA with a discard flag set.
REQ-018 DATA: data_req=0; data_data_ok is ignored in any other state; on data_data_ok=1, latch data_rdata into readdataM on loads only.
REQ-019 DATA on data_data_ok: go to IDLE if discard or flushM is set, else to DONE.
REQ-020 DONE: hold readdataM; go to IDLE when pipe_stall=0 or flushM=1.
REQ-021 SHALL assert stall_mem combinationally in IDLE when starting an access, and in ADDR and DATA unconditionally; it SHALL be 0 in DONE and otherwise.
REQ-022 data_size SHALL be 0 for byte, 1 for half, 2 for word; data_addr SHALL be full aluoutM, not word-aligned.
REQ-023 SB SHALL produce wdata={4{wd[7:0]}} and wstrb=0001<<addr[1:0].
REQ-024 SH SHALL produce wdata={2{wd[15:0]}}, wstrb=0011 when addr[1]=0, and wstrb=1100 otherwise.
REQ-025 SW SHALL produce wdata=wd and wstrb=1111; loads SHALL produce wstrb=0000 and data_wr=0.
REQ-026 readdataM SHALL keep its last value outside DATA completion; stores SHALL NOT modify it.
REQ-027 Minimum aligned-access latency, with addr_ok and data_ok each in their first possible cycle: stall_mem high 3 cycles, low in cycle 4.

Reset
REQ-028 resetn=0 SHALL asynchronously force state IDLE; data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, readdataM, and discard flag 0.
REQ-029 Reset mid-transaction SHALL abandon it; no data_req pulse follows release until a new access.

Verification
REQ-030 LW at 0x1000, addr_ok cycle 1, data_ok cycle 2 with rdata 0xDEADBEEF -> readdataM=0xDEADBEEF; stall_mem 1,1,1,0.
REQ-031 SB at 0x2003, wd 0x000000A5 -> data_wr=1, size=0, wdata=0xA5A5A5A5, wstrb=1000.
REQ-032 SH at 0x2002, wd 0x00001234 -> wdata=0x12341234, wstrb=1100; LH at 0x2001 -> adel=1, badvaddr=0x2001, data_req never 1.
REQ-033 SW at 0x3002 -> ades=1, no request, stall_mem=0.
REQ-034 LW with addr_ok held 0 for 4 cycles -> data_req and data_addr stable, stall_mem=1.
REQ-035 flushM with addr_ok in ADDR -> one request issued, data_ok consumed, readdataM unchanged, state IDLE; repeat with resetn pulsed in DATA -> all outputs 0.
